// File: rtl/universal_shift_reg.sv
// universal_shift_reg: parametrised universal shift register with rotate
// modes, serial outputs and a counted burst mode.
//
// Ports:
//   CP     clock, all state changes on the rising edge
//   CR_n   asynchronous active-low clear
//   D      parallel load data
//   S      mode select (000 hold, 001 shr, 010 shl, 011 load,
//          100 ror, 101 rol, 11x hold)
//   DSR    serial in for right shift, enters at Q[WIDTH-1]
//   DSL    serial in for left shift, enters at Q[0]
//   CNT    burst step count, sampled together with START
//   START  burst request, level-sampled on CP
//   Q      register contents
//   SOR    Q[0]
//   SOL    Q[WIDTH-1]
//   BUSY   high while burst steps execute
//   DONE   one-cycle pulse after a burst completes
module universal_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             CP,
  input  logic             CR_n,
  input  logic [WIDTH-1:0] D,
  input  logic [2:0]       S,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [CNT_W-1:0] CNT,
  input  logic             START,
  output logic [WIDTH-1:0] Q,
  output logic             SOR,
  output logic             SOL,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] q_op;

  // In RUN the latched op drives the datapath; elsewhere the live S does.
  // FIN never uses q_op, so the selection there is irrelevant.
  assign op_sel = (state == RUN) ? op : S;

  // Shared shift/rotate/load datapath for single-cycle and burst steps.
  always_comb begin
    q_op = q;
    case (op_sel)
      3'b001:  q_op = {DSR, q[WIDTH-1:1]};
      3'b010:  q_op = {q[WIDTH-2:0], DSL};
      3'b011:  q_op = D;
      3'b100:  q_op = {q[0], q[WIDTH-1:1]};
      3'b101:  q_op = {q[WIDTH-2:0], q[WIDTH-1]};
      default: q_op = q;
    endcase
  end

  // State register
  always_ff @(posedge CP or negedge CR_n) begin
    if (!CR_n) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = (CNT == '0) ? FIN : RUN;
      // cnt==0 in RUN cannot occur normally; exit rather than spin.
      RUN:     if (cnt <= CNT_W'(1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs, decoded from registered state
  always_comb begin
    BUSY = (state == RUN);
    DONE = (state == FIN);
  end

  // Datapath registers: Q, step counter and latched burst op.
  always_ff @(posedge CP or negedge CR_n) begin
    if (!CR_n) begin
      q   <= '0;
      cnt <= '0;
      op  <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            // START wins over S; Q is left untouched on this edge.
            op  <= S;
            cnt <= CNT;
          end else begin
            q <= q_op;
          end
        end
        RUN: begin
          q <= q_op;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign Q   = q;
  assign SOR = q[0];
  assign SOL = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

  logic       CP = 1'b0;
  logic       CR_n;
  logic [3:0] D;
  logic [2:0] S;
  logic       DSR, DSL;
  logic [3:0] CNT;
  logic       START;
  logic [3:0] Q;
  logic       SOR, SOL, BUSY, DONE;

  int tests = 0;
  int fails = 0;

  universal_shift_reg #(.WIDTH(4), .CNT_W(4)) dut (
    .CP(CP), .CR_n(CR_n), .D(D), .S(S), .DSR(DSR), .DSL(DSL),
    .CNT(CNT), .START(START), .Q(Q), .SOR(SOR), .SOL(SOL),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CP = ~CP;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] q_exp,
                     input logic busy_exp, input logic done_exp);
    tests++;
    if (Q !== q_exp || BUSY !== busy_exp || DONE !== done_exp) begin
      fails++;
      $display("FAIL %s: Q=%b BUSY=%b DONE=%b, expected Q=%b BUSY=%b DONE=%b",
               name, Q, BUSY, DONE, q_exp, busy_exp, done_exp);
    end
  endtask

  task automatic test_reset();
    CR_n = 1'b0; D = '0; S = 3'b000; DSR = 0; DSL = 0; CNT = '0; START = 0;
    step();
    chk("reset", 4'b0000, 1'b0, 1'b0);
    CR_n = 1'b1;
    step();
    chk("reset_release_hold", 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_shift();
    S = 3'b011; D = 4'b1011; step();
    chk("load_1011", 4'b1011, 1'b0, 1'b0);
    S = 3'b001; DSR = 1'b0; step();
    chk("shr_dsr0", 4'b0101, 1'b0, 1'b0);
    tests++;
    if (SOR !== 1'b1 || SOL !== 1'b0) begin
      fails++;
      $display("FAIL serial_out: SOR=%b SOL=%b, expected SOR=1 SOL=0", SOR, SOL);
    end
    S = 3'b010; DSL = 1'b1; step();
    chk("shl_dsl1", 4'b1011, 1'b0, 1'b0);
    S = 3'b001; DSR = 1'b1; step();
    chk("shr_dsr1", 4'b1101, 1'b0, 1'b0);
  endtask

  task automatic test_rotate();
    S = 3'b011; D = 4'b1001; step();
    S = 3'b100; step();
    chk("ror", 4'b1100, 1'b0, 1'b0);
    S = 3'b101; step();
    chk("rol", 4'b1001, 1'b0, 1'b0);
    S = 3'b110; step();
    chk("hold_110", 4'b1001, 1'b0, 1'b0);
    S = 3'b111; step();
    chk("hold_111", 4'b1001, 1'b0, 1'b0);
    S = 3'b000; step();
    chk("hold_000", 4'b1001, 1'b0, 1'b0);
  endtask

  task automatic test_burst();
    S = 3'b011; D = 4'b0001; step();
    S = 3'b101; CNT = 4'd3; START = 1'b1; step();
    chk("burst_start_edge", 4'b0001, 1'b1, 1'b0);
    // Changes in S/D/START during RUN must be ignored.
    START = 1'b0; S = 3'b011; D = 4'b1111; CNT = 4'd9; step();
    chk("burst_step1", 4'b0010, 1'b1, 1'b0);
    step();
    chk("burst_step2", 4'b0100, 1'b1, 1'b0);
    step();
    chk("burst_step3_done", 4'b1000, 1'b0, 1'b1);
    step();
    chk("burst_fin_hold", 4'b1000, 1'b0, 1'b0);
    S = 3'b000;
  endtask

  task automatic test_start_ignored();
    // CNT=0: straight to FIN, Q unchanged.
    S = 3'b001; DSR = 1'b1; CNT = 4'd0; START = 1'b1; step();
    chk("cnt0_done", 4'b1000, 1'b0, 1'b1);
    step();  // START still high in FIN: ignored
    chk("cnt0_fin_start_ignored", 4'b1000, 1'b0, 1'b0);
    // Burst of 2 with START held through RUN and FIN.
    S = 3'b010; DSL = 1'b1; CNT = 4'd2; step();
    chk("start_held_begin", 4'b1000, 1'b1, 1'b0);
    S = 3'b011; D = 4'b1111; CNT = 4'd5; step();
    chk("start_held_step1", 4'b0001, 1'b1, 1'b0);
    step();
    chk("start_held_step2", 4'b0011, 1'b0, 1'b1);
    step();
    chk("start_held_fin", 4'b0011, 1'b0, 1'b0);
    START = 1'b0; S = 3'b000;
    step();
    chk("start_held_idle", 4'b0011, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    S = 3'b011; D = 4'b1011; step();
    S = 3'b001; CNT = 4'd5; START = 1'b1; step();
    chk("abort_start", 4'b1011, 1'b1, 1'b0);
    START = 1'b0; S = 3'b000; DSR = 1'b1; step();
    chk("abort_step1", 4'b1101, 1'b1, 1'b0);
    DSR = 1'b0; step();
    chk("abort_step2", 4'b0110, 1'b1, 1'b0);
    #2 CR_n = 1'b0;
    #1 chk("abort_async_clear", 4'b0000, 1'b0, 1'b0);
    #1 CR_n = 1'b1;
    step();
    chk("abort_no_done1", 4'b0000, 1'b0, 1'b0);
    step();
    chk("abort_no_done2", 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_max_burst();
    int busy_cycles;
    int guard;
    S = 3'b011; D = 4'b0001; step();
    S = 3'b101; CNT = 4'd15; START = 1'b1; step();
    START = 1'b0; S = 3'b000;
    busy_cycles = 0;
    guard = 0;
    while (BUSY === 1'b1 && guard < 40) begin
      busy_cycles++;
      guard++;
      step();
    end
    tests++;
    if (busy_cycles != 15) begin
      fails++;
      $display("FAIL max_burst_len: busy cycles=%0d, expected 15", busy_cycles);
    end
    // 15 left rotations of 4 bits == one right rotation.
    chk("max_burst_result", 4'b1000, 1'b0, 1'b1);
    step();
    chk("max_burst_after", 4'b1000, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_shift();
    test_rotate();
    test_burst();
    test_start_ignored();
    test_abort();
    test_max_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
